// File: rtl/reg_file.sv
// reg_file: 32 x WIDTH register file with one write port and two
// combinational read ports. Register ZERO_REG is hardwired to zero.
// Optional build macro: REGFILE_BYPASS_EN adds a same-cycle write-to-read
// bypass. When the macro is undefined, a read that coincides with a write
// to the same register returns the old value until the clock edge.
module reg_file #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [WIDTH-1:0] r_regs [NREG];
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    // A write is effective only outside reset and never to the zero register
    assign w_wr_en = RegWrite && !reset && (WriteRegister != ZERO_IDX);

    // Register storage: synchronous clear has priority over writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[WriteRegister] <= WriteData;
        end
    end

    // Read port 1: array lookup, optional bypass, zero-register mask last
    always_comb begin
        w_rd1 = r_regs[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (ReadRegister1 == WriteRegister)) begin
            w_rd1 = WriteData;
        end
`endif
        if (ReadRegister1 == ZERO_IDX) begin
            w_rd1 = '0;
        end
    end

    // Read port 2: same structure as port 1
    always_comb begin
        w_rd2 = r_regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (ReadRegister2 == WriteRegister)) begin
            w_rd2 = WriteData;
        end
`endif
        if (ReadRegister2 == ZERO_IDX) begin
            w_rd2 = '0;
        end
    end

    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed testbench for reg_file (default WIDTH=64, ZERO_REG=31).
// Expected values for the same-cycle read-during-write case follow the
// REGFILE_BYPASS_EN macro, so the bench works in both builds.
module tb_reg_file;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       ReadRegister1;
    logic [4:0]       ReadRegister2;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file #(.WIDTH(WIDTH), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs then change 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for combinational reads to settle before sampling
    task automatic settle();
        #1;
    endtask

    logic [WIDTH-1:0] k_step;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic [WIDTH-1:0] exp_byp;

    initial begin
        k_step        = 64'h0101_0101_0101_0101;
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        tick();
        tick();
        reset = 1'b0;

        // Every address reads zero on both ports after reset
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            settle();
            check($sformatf("rst_rd1[%0d]", a), ReadData1, '0);
            check($sformatf("rst_rd2[%0d]", 31 - a), ReadData2, '0);
        end

        // Write X5, read it on both ports, neighbours stay zero
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 64'h0000_0000_DEAD_BEEF;
        tick();
        RegWrite      = 1'b0;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd5;
        settle();
        check("x5_rd1", ReadData1, 64'h0000_0000_DEAD_BEEF);
        check("x5_rd2", ReadData2, 64'h0000_0000_DEAD_BEEF);
        ReadRegister1 = 5'd4;
        ReadRegister2 = 5'd6;
        settle();
        check("x4_zero", ReadData1, '0);
        check("x6_zero", ReadData2, '0);

        // Writes to the zero register never show up, before or after the edge
        RegWrite      = 1'b1;
        WriteRegister = 5'd31;
        WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd31;
        settle();
        check("xzr_pre_rd1", ReadData1, '0);
        check("xzr_pre_rd2", ReadData2, '0);
        tick();
        RegWrite = 1'b0;
        settle();
        check("xzr_post_rd1", ReadData1, '0);
        check("xzr_post_rd2", ReadData2, '0);

        // Read during write to X7: bypass build sees new data, else old
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 64'h11;
        tick();
`ifdef REGFILE_BYPASS_EN
        exp_byp = 64'h22;
`else
        exp_byp = 64'h11;
`endif
        WriteData     = 64'h22;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        settle();
        check("x7_same_rd1", ReadData1, exp_byp);
        check("x7_same_rd2", ReadData2, exp_byp);
        tick();
        RegWrite = 1'b0;
        settle();
        check("x7_after_rd1", ReadData1, 64'h22);
        check("x7_after_rd2", ReadData2, 64'h22);

        // Disabled write to X3 is dropped
        RegWrite      = 1'b0;
        WriteRegister = 5'd3;
        WriteData     = 64'h1234;
        tick();
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd5;
        settle();
        check("x3_nowrite", ReadData1, '0);
        check("x5_hold", ReadData2, 64'h0000_0000_DEAD_BEEF);

        // Write coinciding with reset is discarded; reset clears X5 and X7
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'h5678;
        settle();
        check("x3_in_reset", ReadData1, '0);
        tick();
        reset    = 1'b0;
        RegWrite = 1'b0;
        settle();
        check("x3_after_rst", ReadData1, '0);
        check("x5_after_rst", ReadData2, '0);
        ReadRegister1 = 5'd7;
        settle();
        check("x7_after_rst", ReadData1, '0);

        // Fill all writable registers with i * 0x0101..01
        RegWrite = 1'b1;
        for (int i = 0; i < 32; i++) begin
            WriteRegister = 5'(i);
            WriteData     = WIDTH'(i) * k_step;
            tick();
        end
        RegWrite = 1'b0;

        // Read back pairs (i, 31-i); index 31 always reads zero
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            exp_a = (i == 31) ? '0 : WIDTH'(i) * k_step;
            exp_b = (i == 0) ? '0 : WIDTH'(31 - i) * k_step;
            settle();
            check($sformatf("fill_rd1[%0d]", i), ReadData1, exp_a);
            check($sformatf("fill_rd2[%0d]", 31 - i), ReadData2, exp_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 64, data width of every register.
REQ-002 The block SHALL provide parameter ZERO_REG, default 31, index hardwired to zero (XZR).
REQ-003 The block SHALL provide port clk, input, 1, clock; all state updates on rising edge.
REQ-004 The block SHALL provide port reset, input, 1, synchronous, active-high.
REQ-005 The block SHALL provide port RegWrite, input, 1, write enable.
REQ-006 The block SHALL provide port WriteRegister, input, 5, write address.
REQ-007 The block SHALL provide port WriteData, input, WIDTH, write data.
REQ-008 The block SHALL provide port ReadRegister1, input, 5, read port 1 address.
REQ-009 The block SHALL provide port ReadRegister2, input, 5, read port 2 address.
REQ-010 The block SHALL provide port ReadData1, output, WIDTH, read port 1 data.
REQ-011 The block SHALL provide port ReadData2, output, WIDTH, read port 2 data.

Function
REQ-012 The block SHALL hold 32 registers of WIDTH bits, index 0..31.
REQ-013 The block SHALL, at a rising clk edge with RegWrite=1, reset=0 and WriteRegister != ZERO_REG, load WriteData into the addressed register.
REQ-014 The block SHALL leave all registers unchanged when RegWrite=0.
REQ-015 The block SHALL leave every non-addressed register unchanged on a write.
REQ-016 The block SHALL ignore writes addressed to ZERO_REG; register ZERO_REG stays 0 permanently.
REQ-017 The block SHALL drive ReadData1/ReadData2 combinationally from the register selected by ReadRegister1/ReadRegister2 (zero-cycle read latency).
REQ-018 The block SHALL return 0 on any read port addressing ZERO_REG, regardless of write or bypass activity.
REQ-019 The block SHALL support both read ports addressing the same register simultaneously, returning identical data.
REQ-020 The block SHALL, for a write and a read to the same register in one cycle without bypass, return the pre-edge value during that cycle and the new value after the edge.
REQ-021 The block SHALL produce no X on ReadData1/ReadData2 after the first reset cycle for any in-range address.

Reset
REQ-022 The block SHALL clear all 32 registers to 0 at a rising clk edge with reset=1.
REQ-023 The block SHALL give reset priority over RegWrite; a write coinciding with reset is discarded.
REQ-024 The block SHALL drive ReadData1/ReadData2 to 0 for all addresses in the cycle after reset, bypass path excepted per REQ-026.

Configuration
REQ-025 The block SHALL compile a write-to-read bypass when macro REGFILE_BYPASS_EN is defined.
REQ-026 With REGFILE_BYPASS_EN defined, the block SHALL drive WriteData on a read port when RegWrite=1, reset=0, and its read address equals WriteRegister != ZERO_REG, in the same cycle.
REQ-027 Without REGFILE_BYPASS_EN, the block SHALL have no bypass path; behaviour per REQ-020.

Verification
REQ-028 Reset then read all 32 addresses on both ports -> every ReadData = 0.
REQ-029 Write X5=0x0000_0000_DEAD_BEEF, next cycle ReadRegister1=5, ReadRegister2=5 -> both ports 0x0000_0000_DEAD_BEEF; X4, X6 remain 0.
REQ-030 Write X31=0xFFFF_FFFF_FFFF_FFFF, read 31 on both ports -> 0 before and after the edge.
REQ-031 Hold X7=0x11, drive RegWrite=1, WriteRegister=7, WriteData=0x22, ReadRegister1=7 -> same cycle 0x22 with REGFILE_BYPASS_EN, 0x11 without; 0x22 after the edge in both builds.
REQ-032 Write X3=0x1234 with RegWrite=0 -> X3 reads 0; then assert reset together with a RegWrite=1 write of X3=0x5678 -> X3 reads 0 after the edge.
REQ-033 Write all 31 writable registers with value i*0x0101_0101_0101_0101, read back every pair (i, 31-i) -> exact values; index 31 reads 0.
